// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and width defaults for the conv_seq sequencer.
package conv_pkg;
  typedef enum logic [2:0] {IDLE, LOADX, LOADY, START, WAITC, READZ, FINISH} conv_seq_state_t;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int Z_WIDTH = 2 * DEF_DATA_WIDTH;
  localparam int Z_ADDR_WIDTH = DEF_ADDR_WIDTH + 1;
  function automatic int z_width(input int dw);
    return 2 * dw;
  endfunction
endpackage

// File: rtl/conv_seq_if.sv
// conv_seq_if: host-side input and output streams of the convolution sequencer.
interface conv_seq_if #(parameter int DATA_WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic out_last;
  logic [2*DATA_WIDTH-1:0] out_data;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/conv_seq_zreader.sv
// conv_seq_zreader: walks memZ from 0 to len-1 and streams each sample out with valid/ready.
module conv_seq_zreader #(
  parameter int DW = 16,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic [AW-1:0] len,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          last_hs
);
  logic pend;
  assign last_hs = en & out_valid & out_ready & out_last;
  // pend marks the cycle in which the RAM presents data for raddr
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      raddr     <= '0;
      pend      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (!en) begin
      raddr     <= '0;
      pend      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (out_valid) begin
      if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        raddr     <= raddr + 1'b1;
      end
    end else if (!pend) begin
      pend <= 1'b1;
    end else begin
      pend      <= 1'b0;
      out_valid <= 1'b1;
      out_data  <= rdata;
      out_last  <= raddr == len - 1'b1;
    end
  end
endmodule

// File: rtl/conv_seq.sv
// conv_seq: loads memX/memY from a host stream, runs conv, streams memZ back.
// Define CONV_SEQ_PERF_EN to build the WAITC cycle counter on perf_cycles.
module conv_seq import conv_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    go,
  input  logic [ADDR_WIDTH-1:0]   size_x_i,
  input  logic [ADDR_WIDTH-1:0]   size_y_i,
  conv_seq_if.slave               host,
  output logic                    memX_we,
  output logic [ADDR_WIDTH-1:0]   memX_waddr,
  output logic [DATA_WIDTH-1:0]   memX_wdata,
  output logic                    memY_we,
  output logic [ADDR_WIDTH-1:0]   memY_waddr,
  output logic [DATA_WIDTH-1:0]   memY_wdata,
  output logic                    conv_start,
  output logic [ADDR_WIDTH-1:0]   conv_size_x,
  output logic [ADDR_WIDTH-1:0]   conv_size_y,
  input  logic                    conv_done,
  output logic [ADDR_WIDTH:0]     memZ_raddr,
  input  logic [2*DATA_WIDTH-1:0] memZ_rdata,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [15:0]             perf_cycles
);
  localparam int ZW = z_width(DATA_WIDTH);
  localparam int ZAW = ADDR_WIDTH + 1;
  conv_seq_state_t state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ZAW-1:0] len;
  logic last_hs, xlast, ylast;
  assign len = {1'b0, conv_size_x} + {1'b0, conv_size_y} - 1'b1;
  assign xlast = cnt == conv_size_x - 1'b1;
  assign ylast = cnt == conv_size_y - 1'b1;
  assign host.in_ready = state == LOADX || state == LOADY;
  assign memX_we = state == LOADX && host.in_valid;
  assign memY_we = state == LOADY && host.in_valid;
  assign memX_waddr = memX_we ? cnt : '0;
  assign memY_waddr = memY_we ? cnt : '0;
  assign memX_wdata = memX_we ? host.in_data : '0;
  assign memY_wdata = memY_we ? host.in_data : '0;
  assign conv_start = state == START;
  assign busy = state != IDLE;
  assign done = state == FINISH;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      conv_size_x <= '0;
      conv_size_y <= '0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: if (go) begin
          if (size_x_i != '0 && size_y_i != '0) begin
            conv_size_x <= size_x_i;
            conv_size_y <= size_y_i;
            cnt         <= '0;
            state       <= LOADX;
          end else begin
            err <= 1'b1;
          end
        end
        LOADX: if (host.in_valid) begin
          cnt   <= xlast ? '0 : cnt + 1'b1;
          state <= xlast ? LOADY : LOADX;
        end
        LOADY: if (host.in_valid) begin
          cnt   <= ylast ? '0 : cnt + 1'b1;
          state <= ylast ? START : LOADY;
        end
        START:   state <= WAITC;
        WAITC:   state <= conv_done ? READZ : WAITC;
        READZ:   state <= last_hs ? FINISH : READZ;
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CONV_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) perf_cycles <= '0;
    else if (state == START) perf_cycles <= '0;
    else if (state == WAITC && perf_cycles != 16'hFFFF) perf_cycles <= perf_cycles + 1'b1;
  end
`else
  assign perf_cycles = '0;
`endif
  conv_seq_zreader #(.DW(ZW), .AW(ZAW)) u_zreader (
    .clk       (clk),
    .rstn      (rstn),
    .en        (state == READZ),
    .len       (len),
    .raddr     (memZ_raddr),
    .rdata     (memZ_rdata),
    .out_valid (host.out_valid),
    .out_ready (host.out_ready),
    .out_data  (host.out_data),
    .out_last  (host.out_last),
    .last_hs   (last_hs)
  );
endmodule

// File: tb/tb_conv_seq.sv
// tb_conv_seq: directed runs of conv_seq against behavioural RAMs and a conv model.
module tb_conv_seq;
  logic clk, rstn, go, conv_done;
  logic [4:0] size_x, size_y;
  logic memX_we, memY_we, conv_start, busy, done, err;
  logic [4:0] memX_waddr, memY_waddr, conv_size_x, conv_size_y;
  logic [7:0] memX_wdata, memY_wdata;
  logic [5:0] memZ_raddr;
  logic [15:0] memZ_rdata, perf_cycles;
  logic [7:0] memx [32];
  logic [7:0] memy [32];
  logic [15:0] memz [64];
  logic [7:0] tx [64];
  logic [15:0] expz [64];
  int nvec = 0, nerr = 0;
  conv_seq_if #(.DATA_WIDTH(8)) hif ();
  conv_seq dut (
    .clk(clk), .rstn(rstn), .go(go), .size_x_i(size_x), .size_y_i(size_y), .host(hif),
    .memX_we(memX_we), .memX_waddr(memX_waddr), .memX_wdata(memX_wdata),
    .memY_we(memY_we), .memY_waddr(memY_waddr), .memY_wdata(memY_wdata),
    .conv_start(conv_start), .conv_size_x(conv_size_x), .conv_size_y(conv_size_y),
    .conv_done(conv_done), .memZ_raddr(memZ_raddr), .memZ_rdata(memZ_rdata),
    .busy(busy), .done(done), .err(err), .perf_cycles(perf_cycles)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (memX_we) memx[memX_waddr] <= memX_wdata;
    if (memY_we) memy[memY_waddr] <= memY_wdata;
    memZ_rdata <= memz[memZ_raddr];
  end
  // conv coprocessor model: full linear convolution, done 50 cycles after start
  initial forever begin
    @(negedge clk);
    if (conv_start) begin
      for (int n = 0; n < int'(conv_size_x) + int'(conv_size_y) - 1; n++) begin
        int s;
        s = 0;
        for (int k = 0; k < int'(conv_size_x); k++)
          if (n - k >= 0 && n - k < int'(conv_size_y)) s += int'(memx[k]) * int'(memy[n-k]);
        memz[n] = 16'(s);
      end
      repeat (50) @(posedge clk);
      #1 conv_done = 1'b1;
      @(posedge clk);
      #1 conv_done = 1'b0;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    int t;
    hif.in_valid = 1'b1;
    hif.in_data = b;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!hif.in_ready && t < 100);
    if (t >= 100) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_go(input logic [4:0] sx, input logic [4:0] sy);
    @(posedge clk);
    #1 go = 1'b1; size_x = sx; size_y = sy;
    @(posedge clk);
    #1 go = 1'b0;
  endtask
  task automatic run(input int sx, input int sy, input bit toggle, input bit go_in_wait, input int nexp);
    int k;
    bit fin, pv, pr;
    logic [15:0] pd;
    pulse_go(5'(sx), 5'(sy));
    @(negedge clk);
    check("go_to_in_ready", hif.in_ready, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < sx + sy; i++) send(tx[i]);
    hif.in_valid = 1'b0;
    @(negedge clk);
    check("conv_start_after_load", conv_start, 1);
    if (go_in_wait) begin
      repeat (5) @(posedge clk);
      #1 go = 1'b1; size_x = 5'd3; size_y = 5'd3;
      @(posedge clk);
      #1 go = 1'b0;
      @(negedge clk);
      check("go_in_waitc_ignored", {err, busy, conv_size_x, conv_size_y}, {1'b0, 1'b1, 5'(sx), 5'(sy)});
    end
    k = 0; fin = 0; pv = 0; pr = 0; pd = '0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(posedge clk);
      #1 hif.out_ready = toggle ? ((c / 3) % 2 == 0) : 1'b1;
      @(negedge clk);
      if (pv && !pr) check("stall_hold", {hif.out_valid, hif.out_data}, {1'b1, pd});
      if (hif.out_valid && hif.out_ready) begin
        check("zdata", hif.out_data, expz[k]);
        check("zlast", hif.out_last, k == nexp - 1);
        fin = hif.out_last;
        k++;
      end
      pv = hif.out_valid; pr = hif.out_ready; pd = hif.out_data;
    end
    check("beat_count", k, nexp);
    @(negedge clk);
    check("done_pulse", {done, busy}, 2'b11);
    @(negedge clk);
    check("idle_after_done", {done, busy}, 2'b00);
  endtask
  initial begin
    rstn = 1'b0; go = 1'b0; conv_done = 1'b0; size_x = '0; size_y = '0;
    hif.in_valid = 1'b0; hif.in_data = '0; hif.out_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin memz[i] = '0; expz[i] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, done, err, conv_start, hif.in_ready, hif.out_valid, hif.out_last,
                            memX_we, memY_we, conv_size_x, conv_size_y, memZ_raddr, perf_cycles}, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 5; i++) tx[i] = 8'd1;
    for (int i = 0; i < 10; i++) tx[5+i] = 8'(i + 1);
    expz[0] = 1;  expz[1] = 3;   expz[2] = 6;   expz[3] = 10;  expz[4] = 15;
    expz[5] = 20; expz[6] = 25;  expz[7] = 30;  expz[8] = 35;  expz[9] = 40;
    expz[10] = 34; expz[11] = 27; expz[12] = 19; expz[13] = 10;
    run(5, 10, 1'b0, 1'b0, 14);
`ifdef CONV_SEQ_PERF_EN
    check("perf_cycles", perf_cycles, 50);
`else
    check("perf_cycles", perf_cycles, 0);
`endif
    run(5, 10, 1'b1, 1'b0, 14);
    pulse_go(5'd0, 5'd3);
    @(negedge clk);
    check("zero_size_err", {err, busy, memX_we, hif.in_ready}, 4'b1000);
    @(negedge clk);
    check("err_one_cycle", {err, busy}, 2'b00);
    run(5, 10, 1'b0, 1'b1, 14);
    pulse_go(5'd5, 5'd10);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send(tx[i]);
    check("mid_loady_write", {busy, memY_we}, 2'b11);
    #2 rstn = 1'b0;
    #1 check("async_reset_outputs", {busy, done, err, conv_start, hif.in_ready, hif.out_valid,
                                     memX_we, memY_we, memY_waddr, memY_wdata, conv_size_x, conv_size_y}, 0);
    hif.in_valid = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    tx[0] = 8'd3; tx[1] = 8'd4;
    expz[0] = 16'd12;
    run(1, 1, 1'b0, 1'b0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
